// File: rtl/tank_damage_controller.sv
// Two-tank hit resolution: per-frame damage, invulnerability windows, lives and
// the IDLE/PLAY/OVER match sequencer read by the renderer and tank movers.

module tank_damage_lane #(
  parameter int LIVES         = 3,
  parameter int INVULN_FRAMES = 60
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       load,
  input  logic       tick,
  input  logic       hit,
  output logic [1:0] lives,
  output logic [1:0] lives_d,
  output logic       armed_d,
  output logic       hit_acc
);
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] lives_q;

  always_comb begin
    cnt_d   = cnt_q;
    lives_d = lives_q;
    hit_acc = 1'b0;
    if (load) begin
      cnt_d   = 8'd0;
      lives_d = 2'(LIVES);
    end else if (tick) begin
      if (cnt_q != 8'd0) begin
        cnt_d = cnt_q - 8'd1;
      end else if (hit && lives_q != 2'd0) begin
        hit_acc = 1'b1;
        lives_d = lives_q - 2'd1;
        cnt_d   = 8'(INVULN_FRAMES);
      end
    end
    armed_d = (cnt_d != 8'd0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= 8'd0;
      lives_q <= 2'(LIVES);
    end else begin
      cnt_q   <= cnt_d;
      lives_q <= lives_d;
    end
  end

  assign lives = lives_q;
endmodule

module tank_damage_controller #(
  parameter int LIVES         = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int OVER_FRAMES   = 180
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       hit_t1,
  input  logic       hit_t2,
  output logic [1:0] lives_t1,
  output logic [1:0] lives_t2,
  output logic       invuln_t1,
  output logic       invuln_t2,
  output logic       clear_bullets_t1,
  output logic       clear_bullets_t2,
  output logic [1:0] game_state,
  output logic [1:0] winner
);
  localparam int NT = 2;
  localparam int OW = $clog2(OVER_FRAMES + 1);

  typedef enum logic [1:0] {S_IDLE = 2'b00, S_PLAY = 2'b01, S_OVER = 2'b10} state_t;

  state_t               state_q, state_d;
  logic [1:0]           winner_q, winner_d;
  logic [OW-1:0]        over_q, over_d;
  logic [NT-1:0]        hit_v, armed_d, hit_acc, invuln_q, clr_q;
  logic [NT-1:0][1:0]   lives_v, lives_nx;
  logic                 load, play_tick;

  assign hit_v     = {hit_t2, hit_t1};
  assign load      = (state_q == S_IDLE) && start;
  assign play_tick = (state_q == S_PLAY) && frame_tick;

  for (genvar g = 0; g < NT; g++) begin : g_lane
    tank_damage_lane #(.LIVES(LIVES), .INVULN_FRAMES(INVULN_FRAMES)) u_lane (
      .clock   (clock),
      .reset_n (reset_n),
      .load    (load),
      .tick    (play_tick),
      .hit     (hit_v[g]),
      .lives   (lives_v[g]),
      .lives_d (lives_nx[g]),
      .armed_d (armed_d[g]),
      .hit_acc (hit_acc[g])
    );
  end

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    over_d   = over_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d  = S_PLAY;
        winner_d = 2'b00;
      end
      S_PLAY: if (frame_tick && (lives_nx[0] == 2'd0 || lives_nx[1] == 2'd0)) begin
        // bit1 = tank 2 wins (tank 1 out), bit0 = tank 1 wins; both set is a draw
        state_d  = S_OVER;
        over_d   = OW'(OVER_FRAMES);
        winner_d = {lives_nx[0] == 2'd0, lives_nx[1] == 2'd0};
      end
      S_OVER: if (frame_tick) begin
        over_d = over_q - OW'(1);
        if (over_q <= OW'(1)) begin
          state_d = S_IDLE;
          over_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      winner_q <= 2'b00;
      over_q   <= '0;
      invuln_q <= '0;
      clr_q    <= '0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      over_q   <= over_d;
      invuln_q <= (state_d == S_PLAY) ? armed_d : '0;
      // a hit on one tank despawns the opposing shooter's bullets
      clr_q    <= {hit_acc[0], hit_acc[1]};
    end
  end

  assign lives_t1         = lives_v[0];
  assign lives_t2         = lives_v[1];
  assign invuln_t1        = invuln_q[0];
  assign invuln_t2        = invuln_q[1];
  assign clear_bullets_t1 = clr_q[0];
  assign clear_bullets_t2 = clr_q[1];
  assign game_state       = state_q;
  assign winner           = winner_q;
endmodule

// File: tb/tb_tank_damage_controller.sv
// Directed bench for tank_damage_controller: hits, invulnerability, game over, reset abort.

module tb_tank_damage_controller;
  logic       clock = 1'b0;
  logic       reset_n;
  logic       frame_tick, start, hit_t1, hit_t2;
  logic [1:0] lives_t1, lives_t2, game_state, winner;
  logic       invuln_t1, invuln_t2, clear_bullets_t1, clear_bullets_t2;

  int total = 0;
  int bad   = 0;

  tank_damage_controller #(.LIVES(3), .INVULN_FRAMES(60), .OVER_FRAMES(4)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .frame_tick       (frame_tick),
    .start            (start),
    .hit_t1           (hit_t1),
    .hit_t2           (hit_t2),
    .lives_t1         (lives_t1),
    .lives_t2         (lives_t2),
    .invuln_t1        (invuln_t1),
    .invuln_t2        (invuln_t2),
    .clear_bullets_t1 (clear_bullets_t1),
    .clear_bullets_t2 (clear_bullets_t2),
    .game_state       (game_state),
    .winner           (winner)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // one frame_tick with the given hit levels; returns at the negedge where N+1 is visible
  task automatic tick(input logic h1, input logic h2);
    @(negedge clock);
    frame_tick = 1'b1; hit_t1 = h1; hit_t2 = h2;
    @(negedge clock);
    frame_tick = 1'b0; hit_t1 = 1'b0; hit_t2 = 1'b0;
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
  endtask

  task automatic do_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  initial begin
    int pulses, inv_hi;
    reset_n = 1'b0; frame_tick = 1'b0; start = 1'b0; hit_t1 = 1'b0; hit_t2 = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_state", game_state, 0);
    chk("rst_lives1", lives_t1, 3);
    chk("rst_lives2", lives_t2, 3);
    chk("rst_winner", winner, 0);
    chk("rst_inv", {invuln_t1, invuln_t2}, 0);
    chk("rst_clr", {clear_bullets_t1, clear_bullets_t2}, 0);
    reset_n = 1'b1;

    // hits and ticks in IDLE are ignored
    tick(1'b1, 1'b1);
    chk("idle_lives", {lives_t1, lives_t2}, 4'hF);

    // start coincident with a tick and hit: tick ignored
    @(negedge clock);
    start = 1'b1; frame_tick = 1'b1; hit_t2 = 1'b1;
    @(negedge clock);
    start = 1'b0; frame_tick = 1'b0; hit_t2 = 1'b0;
    chk("start_state", game_state, 1);
    chk("start_lives", {lives_t1, lives_t2}, 4'hF);
    chk("start_winner", winner, 0);
    chk("start_clr", {clear_bullets_t1, clear_bullets_t2}, 0);

    // held hit on tank 2 over 70 ticks
    tick(1'b0, 1'b1);
    chk("h1_lives2", lives_t2, 2);
    chk("h1_clr1", clear_bullets_t1, 1);
    chk("h1_clr2", clear_bullets_t2, 0);
    chk("h1_inv2", invuln_t2, 1);
    @(negedge clock);
    chk("h1_clr1_width", clear_bullets_t1, 0);
    pulses = 0; inv_hi = 1;
    for (int t = 2; t <= 61; t++) begin
      tick(1'b0, 1'b1);
      pulses += int'(clear_bullets_t1);
      inv_hi += int'(invuln_t2);
    end
    chk("inv_pulses", pulses, 0);
    chk("inv_ticks", inv_hi, 60);
    chk("inv_drop", invuln_t2, 0);
    chk("t61_lives2", lives_t2, 2);
    tick(1'b0, 1'b1);
    chk("t62_lives2", lives_t2, 1);
    chk("t62_clr1", clear_bullets_t1, 1);
    for (int t = 63; t <= 70; t++) tick(1'b0, 1'b1);
    chk("t70_lives2", lives_t2, 1);

    // hit_t1 only between ticks
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock); hit_t1 = 1'b1;
      @(negedge clock); hit_t1 = 1'b0; frame_tick = 1'b1;
      @(negedge clock); frame_tick = 1'b0;
      pulses += int'(clear_bullets_t2);
    end
    chk("off_tick_lives1", lives_t1, 3);
    chk("off_tick_pulses", pulses, 0);

    // bring tank 1 to 1 life, then simultaneous kill
    tick(1'b1, 1'b0);
    chk("t1_first", lives_t1, 2);
    quiet(61);
    tick(1'b1, 1'b0);
    chk("t1_second", lives_t1, 1);
    quiet(61);
    tick(1'b1, 1'b1);
    chk("sim_lives", {lives_t1, lives_t2}, 0);
    chk("sim_clr", {clear_bullets_t1, clear_bullets_t2}, 2'b11);
    chk("sim_winner", winner, 3);
    chk("sim_state", game_state, 2);
    chk("sim_inv", {invuln_t1, invuln_t2}, 0);
    quiet(3);
    chk("sim_over3", game_state, 2);
    quiet(1);
    chk("sim_idle", game_state, 0);
    chk("sim_winner_hold", winner, 3);

    // second match: tank 1 wiped out alone
    do_start();
    chk("m2_lives", {lives_t1, lives_t2}, 4'hF);
    chk("m2_winner", winner, 0);
    tick(1'b1, 1'b0); quiet(61);
    tick(1'b1, 1'b0); quiet(61);
    tick(1'b1, 1'b0);
    chk("m2_lives1", lives_t1, 0);
    chk("m2_lives2", lives_t2, 3);
    chk("m2_clr2", clear_bullets_t2, 1);
    chk("m2_winner_t2", winner, 2);
    chk("m2_state", game_state, 2);
    quiet(3);
    do_start();
    chk("m2_start_over", game_state, 2);
    chk("m2_lives_over", lives_t1, 0);
    quiet(1);
    chk("m2_idle", game_state, 0);
    chk("m2_winner_hold", winner, 2);
    do_start();
    chk("m3_lives", {lives_t1, lives_t2}, 4'hF);
    chk("m3_winner", winner, 0);

    // mid-match reset with invuln_t1 high, lives 1/2, clear pulse in flight
    tick(1'b1, 1'b1); quiet(61);
    tick(1'b1, 1'b0);
    chk("pre_rst_lives", {lives_t1, lives_t2}, 4'b0110);
    chk("pre_rst_inv1", invuln_t1, 1);
    chk("pre_rst_clr2", clear_bullets_t2, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_state", game_state, 0);
    chk("async_lives", {lives_t1, lives_t2}, 4'hF);
    chk("async_inv", {invuln_t1, invuln_t2}, 0);
    chk("async_clr", {clear_bullets_t1, clear_bullets_t2}, 0);
    chk("async_winner", winner, 0);
    repeat (3) @(negedge clock);
    chk("rst_hold_clr", {clear_bullets_t1, clear_bullets_t2}, 0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_state", game_state, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tank_damage_controller.md
# tank_damage_controller

Sequences hit resolution for the two-tank arena. Each frame it samples the level-sensitive bullet-versus-tank overlap flags from the collision logic and applies at most one hit per tank per frame. It enforces a post-hit invulnerability window, tracks lives per tank and requests despawn of the shooter's bullets after each scored hit. It also runs the match state machine (idle / play / game over) that the renderer and tank movers read.

## Interface
- LIVES, 3, lives per tank at match start; legal range 1..3.
- INVULN_FRAMES, 60, frames a tank ignores hits after being hit; legal range 1..255.
- OVER_FRAMES, 180, frames spent in OVER before returning to IDLE; legal range 1..1023.

- clock  input  1  system clock, all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- frame_tick  input  1  one-cycle pulse once per video frame (vsync start).
- start  input  1  one-cycle pulse, begin a match.
- hit_t1  input  1  level: a tank-2 bullet overlaps tank 1.
- hit_t2  input  1  level: a tank-1 bullet overlaps tank 2.
- lives_t1, lives_t2  output  2  remaining lives.
- invuln_t1, invuln_t2  output  1  high while the tank's invulnerability counter is nonzero.
- clear_bullets_t1, clear_bullets_t2  output  1  one-cycle pulse: despawn all bullets fired by tank 1 / tank 2.
- game_state  output  2  00 IDLE, 01 PLAY, 10 OVER; 11 never driven.
- winner  output  2  00 none, 01 tank 1, 10 tank 2, 11 draw.

## Operation
- Reset (async, reset_n=0) values:
  - game_state=IDLE, lives_t1=lives_t2=LIVES, winner=00.
  - Invulnerability and over counters =0, so invuln_t1=invuln_t2=0.
  - clear_bullets_t1=clear_bullets_t2=0.
  - Reset mid-match aborts immediately with no pulse emitted.
- IDLE:
  - hit_t* and frame_tick are ignored.
  - start=1: load lives_t1=lives_t2=LIVES, clear both invulnerability counters, winner=00, go to PLAY.
- PLAY, frame_tick=1 cycle only; hit_t* are not sampled on other cycles. Per tank X, evaluated independently:
  - Invulnerability counter nonzero: decrement by 1; hit_tX ignored this tick.
  - Counter zero and hit_tX=1: lives_tX -= 1, counter loaded with INVULN_FRAMES, assert the clear pulse for the opposing shooter. A tank-1 hit pulses clear_bullets_t2; a tank-2 hit pulses clear_bullets_t1.
  - Counter zero and hit_tX=0: no change.
- Game-over check uses post-update lives on the same tick:
  - Both zero: winner=11.
  - Only lives_t1 zero: winner=10.
  - Only lives_t2 zero: winner=01.
  - On any of these, go to OVER and load the over counter with OVER_FRAMES.
- Simultaneous hits on the same tick are both applied. Both clear pulses fire together.
- Lives never wrap below 0. A hit is impossible at 0 because the state has already left PLAY.
- start while in PLAY or OVER is ignored.
- OVER:
  - Decrement the over counter on each frame_tick.
  - On the tick where it reaches 0, go to IDLE.
  - winner and lives hold until the next start.
  - Invulnerability counters freeze; invuln_* are forced to 0 in IDLE and OVER.
- Counter widths: invulnerability counter 8 bits; over counter $clog2(OVER_FRAMES+1) bits.

## Timing
- All outputs are registered.
- Hit sampled on frame_tick cycle N:
  - lives_tX, invuln_tX and the clear pulse are visible at cycle N+1.
  - The clear pulse is high for exactly cycle N+1.
- game_state changes to OVER and winner updates at N+1, the same edge as the final lives update.
- Invulnerability window:
  - A hit on tick K is ignored on ticks K+1 .. K+INVULN_FRAMES.
  - invuln_tX drops at the edge after tick K+INVULN_FRAMES.
  - A hit is accepted again on tick K+INVULN_FRAMES+1.
- start at cycle N in IDLE gives game_state=PLAY at N+1. A frame_tick coincident with start is ignored; the first hit sample is the next tick.
- OVER entered after tick N: return to IDLE after the OVER_FRAMES-th subsequent tick, visible one cycle later.

## Test plan
- Reset then start:
  - Expect lives 3/3, game_state=01, winner=00, all clear pulses 0.
- hit_t2=1 held continuously across 70 ticks (INVULN_FRAMES=60):
  - lives_t2 goes 3→2 after tick 1.
  - clear_bullets_t1 pulses exactly once, one cycle wide.
  - invuln_t2 high for 60 ticks.
  - Second decrement 2→1 on tick 62.
- hit_t1 and hit_t2 both high on one tick, both tanks at 1 life:
  - Both lives 0, both clear pulses in the same cycle, winner=11, game_state=10.
- hit_t1 high on cycles between ticks only (never on a tick):
  - lives_t1 stays 3, no pulses.
- Tank 1 reduced to 0 with OVER_FRAMES=4:
  - winner=10 and game_state=10.
  - game_state=00 one cycle after the 4th following tick.
  - start during OVER is ignored; start in IDLE restores lives 3/3.
- reset_n asserted mid-PLAY with invuln_t1=1 and lives 1/2:
  - Outputs return to reset values immediately (asynchronous), without waiting for a clock edge.
  - No clear pulse is emitted.
